// File: rtl/vout_frequency.sv
// Square-wave generator: emits a ~50% duty wave whose period (in clk cycles) is latched at each period boundary.
// Latency: SIGNAL rises 1 clk after a qualifying enable/period in IDLE; no backpressure, inputs only sampled at boundaries.
module vout_frequency #(
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] period,
  output logic        SIGNAL,
  output logic        active,
  output logic [31:0] pulse_count
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pe_q, pe_d;
  logic [31:0] pulse_count_q, pulse_count_d;
  logic        signal_q, signal_d;

  logic        start_req;
  logic [31:0] req_pe;
  logic [31:0] req_hi_m1;
  logic [31:0] lo_m1;

  // Requested period after clamping; the high phase takes the extra cycle of an odd period.
  assign start_req = enable && (period != 32'd0);
  assign req_pe    = (period < MIN_P) ? MIN_P : period;
  assign req_hi_m1 = req_pe - (req_pe >> 1) - 32'd1;
  assign lo_m1     = (pe_q >> 1) - 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 32'd0;
      pe_q          <= 32'd0;
      pulse_count_q <= 32'd0;
      signal_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pe_q          <= pe_d;
      pulse_count_q <= pulse_count_d;
      signal_q      <= signal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pe_d          = pe_q;
    pulse_count_d = pulse_count_q;
    signal_d      = signal_q;

    unique case (state_q)
      IDLE: begin
        signal_d = 1'b0;
        if (start_req) begin
          state_d       = HIGH;
          signal_d      = 1'b1;
          cnt_d         = req_hi_m1;
          pe_d          = req_pe;
          pulse_count_d = pulse_count_q + 32'd1;
        end
      end

      HIGH: begin
        if (cnt_q == 32'd0) begin
          state_d  = LOW;
          signal_d = 1'b0;
          cnt_d    = lo_m1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      LOW: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (start_req) begin
          // Period boundary: the only point where new enable/period values take effect.
          state_d       = HIGH;
          signal_d      = 1'b1;
          cnt_d         = req_hi_m1;
          pe_d          = req_pe;
          pulse_count_d = pulse_count_q + 32'd1;
        end else begin
          state_d  = IDLE;
          signal_d = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        signal_d = 1'b0;
      end
    endcase
  end

  assign SIGNAL      = signal_q;
  assign active      = (state_q != IDLE);
  assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_vout_frequency.sv
// Bench for vout_frequency: a period-level model predicts each rising edge and stop;
// a monitor sampling on the falling clock edge pops and compares the predictions.
module tb_vout_frequency;

  localparam int unsigned MIN_P = 2;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] period;
  logic        SIGNAL;
  logic        active;
  logic [31:0] pulse_count;

  vout_frequency #(.MIN_PERIOD(MIN_P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .period     (period),
    .SIGNAL     (SIGNAL),
    .active     (active),
    .pulse_count(pulse_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_rise;
    longint      edge_no;
    int unsigned hi;
    int unsigned cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  longint      edge_cnt = 0;
  bit          started = 0;

  // Reference model state: whether a period is running and the edge of the next boundary.
  bit          m_run = 0;
  longint      m_next = 0;
  int unsigned m_cnt = 0;

  bit          r_en;
  logic [31:0] r_per;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs for the next clock edge, let the model predict what that edge does, then advance.
  task automatic step(input bit en, input logic [31:0] per);
    longint      e;
    int unsigned pe;
    exp_t        x;
    enable = en;
    period = per;
    e = edge_cnt + 1;
    if (!m_run || e == m_next) begin
      if (en && per != 0) begin
        pe = (per < MIN_P) ? MIN_P : per;
        m_cnt++;
        x.is_rise = 1'b1; x.edge_no = e; x.hi = (pe + 1) / 2; x.cnt = m_cnt;
        q.push_back(x);
        m_run  = 1'b1;
        m_next = e + longint'(pe);
      end else if (m_run) begin
        x.is_rise = 1'b0; x.edge_no = e; x.hi = 0; x.cnt = m_cnt;
        q.push_back(x);
        m_run = 1'b0;
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor
  bit          prev_sig = 0;
  bit          prev_act = 0;
  int unsigned hi_run = 0;
  int unsigned cur_hi = 0;
  int unsigned last_cnt = 0;
  exp_t        m_e;

  always @(negedge clk) begin
    if (!rst_n || !started) begin
      prev_sig = 0;
      prev_act = 0;
      hi_run   = 0;
      last_cnt = 0;
    end else begin
      if (SIGNAL === 1'b1 && !prev_sig) begin
        if (q.size() == 0 || !q[0].is_rise) begin
          checks++; errors++;
          $display("FAIL unexpected_rise: got rise at edge %0d, expected none", edge_cnt);
        end else begin
          m_e = q.pop_front();
          chk("rise_edge", 64'(edge_cnt), 64'(m_e.edge_no));
          chk("pulse_count_at_rise", 64'(pulse_count), 64'(m_e.cnt));
          cur_hi   = m_e.hi;
          last_cnt = m_e.cnt;
        end
        hi_run = 1;
      end else if (SIGNAL === 1'b1) begin
        hi_run++;
      end
      if (SIGNAL !== 1'b1 && prev_sig) chk("high_len", 64'(hi_run), 64'(cur_hi));
      if (active === 1'b1 && !prev_act) chk("active_rises_with_signal", {63'd0, SIGNAL}, 64'd1);
      if (active !== 1'b1 && prev_act) begin
        if (q.size() == 0 || q[0].is_rise) begin
          checks++; errors++;
          $display("FAIL unexpected_stop: got stop at edge %0d, expected none", edge_cnt);
        end else begin
          m_e = q.pop_front();
          chk("stop_edge", 64'(edge_cnt), 64'(m_e.edge_no));
        end
      end
      chk("pulse_count_hold", 64'(pulse_count), 64'(last_cnt));
      chk("idle_signal_low", {63'd0, (SIGNAL && !active)}, 64'd0);
      prev_sig = (SIGNAL === 1'b1);
      prev_act = (active === 1'b1);
    end
  end

  initial begin
    bit got_high;
    rst_n  = 1'b1;
    enable = 1'b0;
    period = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_signal", {63'd0, SIGNAL}, 64'd0);
    chk("reset_active", {63'd0, active}, 64'd0);
    chk("reset_pulse_count", 64'(pulse_count), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n   = 1'b1;
    started = 1'b1;

    repeat (3) step(1'b0, 32'd10);
    repeat (50) step(1'b1, 32'd10);
    repeat (21) step(1'b1, 32'd7);
    repeat (8) step(1'b1, 32'd1);
    repeat (8) step(1'b1, 32'd2);
    repeat (13) step(1'b1, 32'd10);
    repeat (45) step(1'b1, 32'd20);
    repeat (22) step(1'b1, 32'd10);
    repeat (20) step(1'b0, 32'd10);
    repeat (13) step(1'b1, 32'd10);
    repeat (20) step(1'b1, 32'd0);
    repeat (3) step(1'b1, 32'd3);

    // Asynchronous reset in the middle of a high phase.
    got_high = 1'b0;
    for (int i = 0; i < 40 && !got_high; i++) begin
      step(1'b1, 32'd10);
      if (SIGNAL === 1'b1) got_high = 1'b1;
    end
    if (!got_high) begin
      checks++; errors++;
      $display("FAIL reset_setup: got no high phase within 40 cycles, expected one");
    end
    step(1'b1, 32'd10);
    rst_n = 1'b0;
    #1;
    chk("async_reset_signal", {63'd0, SIGNAL}, 64'd0);
    chk("async_reset_active", {63'd0, active}, 64'd0);
    chk("async_reset_pulse_count", 64'(pulse_count), 64'd0);
    q.delete();
    m_run = 1'b0;
    m_cnt = 0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) step(1'b0, 32'd10);
    repeat (4) step(1'b1, 32'd0);
    repeat (30) step(1'b1, 32'd4);

    r_en  = 1'b1;
    r_per = 32'd10;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r_en  = ($urandom_range(0, 4) != 0);
        r_per = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(4, 24));
      end
      step(r_en, r_per);
    end

    for (int i = 0; i < 200 && m_run; i++) step(1'b0, 32'd0);
    repeat (3) step(1'b0, 32'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("final_active", {63'd0, active}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
